pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the single-cycle decoder for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
- Decodes the ID-stage instruction using real MIPS encodings.
- Carries control bits through registered ID/EX, EX/MEM and MEM/WB control stages.
- Generates load-use stall, jump/branch flush and destination-register tags for the forwarding unit.

---
 rtl/pipe_ctrl_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
//   Pipelined control unit for a 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
//   It decodes the instruction held in IF/ID and carries the resulting
//   control bits through registered ID/EX, EX/MEM and MEM/WB stages. It also
//   produces the load-use stall, the IF/ID flush for jumps and taken branches,
//   and per-stage destination-register tags for the forwarding unit.
//
// Ports
//   Clk, Rst        clock; synchronous active-high reset
//   InstrID         instruction in the IF/ID register
//   InstrValid      qualifies InstrID; 0 decodes as a bubble
//   BranchTakenEX   EX stage resolved a taken branch this cycle
//   Stall           hold PC and IF/ID (combinational)
//   FlushIFID       zero IF/ID on the next edge (combinational)
//   ALUSrcEX, RegDstEX, BranchEX, OPCodeEX, FunctEX, RtFieldEX   EX controls
//   MemReadMEM, MemWriteMEM, MemSizeMEM                          MEM controls
//   RegWriteWB, MemtoRegWB, LinkWB                               WB controls
//   DestEX, DestMEM, DestWB  write register per stage (0 = no write)
//
// Handshake: there is no backpressure on this block. InstrValid is a plain
// qualifier sampled every cycle; when it is low nothing about InstrID is
// decoded, stalled on or flushed. Stall is the only "not ready" signal and
// it is addressed to the fetch side (PC and IF/ID hold).
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
   parameter int INSTR_W   = 32,
   parameter int REG_AW    = 5,
   parameter int LINK_REG  = 31,
   parameter int EN_HAZARD = 1
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [INSTR_W-1:0] InstrID,
   input  logic               InstrValid,
   input  logic               BranchTakenEX,
   output logic               Stall,
   output logic               FlushIFID,
   output logic               ALUSrcEX,
   output logic               RegDstEX,
   output logic               BranchEX,
   output logic [5:0]         OPCodeEX,
   output logic [5:0]         FunctEX,
   output logic [REG_AW-1:0]  RtFieldEX,
   output logic               MemReadMEM,
   output logic               MemWriteMEM,
   output logic [1:0]         MemSizeMEM,
   output logic               RegWriteWB,
   output logic               MemtoRegWB,
   output logic               LinkWB,
   output logic [REG_AW-1:0]  DestEX,
   output logic [REG_AW-1:0]  DestMEM,
   output logic [REG_AW-1:0]  DestWB
);

   // ---------------------------------------------------------------- fields
   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic              w_unused_bits;

   assign w_op    = InstrID[31:26];
   assign w_funct = InstrID[5:0];
   assign w_rs    = REG_AW'(InstrID[25:21]);
   assign w_rt    = REG_AW'(InstrID[20:16]);
   assign w_rd    = REG_AW'(InstrID[15:11]);
   // shamt (and any bits above 31) are not control-relevant
   assign w_unused_bits = ^InstrID[10:6] ^ ^InstrID[INSTR_W-1:26];

   // ---------------------------------------------------------------- decode
   logic              w_legal;
   logic              w_alu_src;
   logic              w_reg_dst;
   logic              w_branch;
   logic              w_jump;
   logic              w_mem_read;
   logic              w_mem_write;
   logic [1:0]        w_mem_size;
   logic              w_reg_write;
   logic              w_mem_to_reg;
   logic              w_link;
   logic              w_uses_rt;
   logic [REG_AW-1:0] w_dest;
   logic [5:0]        w_op_fwd;
   logic [5:0]        w_funct_fwd;
   logic [REG_AW-1:0] w_rt_fwd;

   always_comb begin
      w_legal      = 1'b0;
      w_alu_src    = 1'b0;
      w_reg_dst    = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_size   = 2'b00;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_link       = 1'b0;
      w_uses_rt    = 1'b0;
      w_dest       = '0;

      if (InstrValid) begin
         case (w_op)
            6'h00: begin
               w_legal   = 1'b1;
               w_uses_rt = 1'b1;
               if (w_funct == 6'h08) begin
                  w_jump = 1'b1;              // JR
               end else begin
                  w_reg_dst   = 1'b1;
                  w_reg_write = 1'b1;
               end
            end
            6'h1C: begin                      // MUL, R-type format
               w_legal     = 1'b1;
               w_uses_rt   = 1'b1;
               w_reg_dst   = 1'b1;
               w_reg_write = 1'b1;
            end
            6'h01: begin                      // REGIMM: only BLTZ/BGEZ exist
               if (InstrID[20:17] == 4'd0) begin
                  w_legal  = 1'b1;
                  w_branch = 1'b1;
               end
            end
            6'h02: begin
               w_legal = 1'b1;
               w_jump  = 1'b1;
            end
            6'h03: begin
               w_legal     = 1'b1;
               w_jump      = 1'b1;
               w_reg_write = 1'b1;
               w_link      = 1'b1;
            end
            6'h04, 6'h05: begin               // BEQ/BNE compare rs with rt
               w_legal   = 1'b1;
               w_branch  = 1'b1;
               w_uses_rt = 1'b1;
            end
            6'h06, 6'h07: begin
               w_legal  = 1'b1;
               w_branch = 1'b1;
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
               w_legal     = 1'b1;
               w_alu_src   = 1'b1;
               w_reg_write = 1'b1;
            end
            6'h20, 6'h21, 6'h23: begin
               w_legal      = 1'b1;
               w_alu_src    = 1'b1;
               w_mem_read   = 1'b1;
               w_mem_to_reg = 1'b1;
               w_reg_write  = 1'b1;
               w_mem_size   = w_op[1:0];      // 00 byte, 01 half, 11 -> word
               if (w_op[1]) w_mem_size = 2'b10;
            end
            6'h28, 6'h29, 6'h2B: begin
               w_legal     = 1'b1;
               w_uses_rt   = 1'b1;
               w_alu_src   = 1'b1;
               w_mem_write = 1'b1;
               w_mem_size  = w_op[1:0];
               if (w_op[1]) w_mem_size = 2'b10;
            end
            default: ;
         endcase

         if (w_link)         w_dest = REG_AW'(LINK_REG);
         else if (w_reg_dst) w_dest = w_rd;
         else                w_dest = w_rt;

         // $0 is never written; a tag is only published for a real write so
         // the forwarding unit never matches a non-writing instruction.
         if (w_dest == '0) w_reg_write = 1'b0;
         if (!w_reg_write) w_dest = '0;
      end
   end

   assign w_op_fwd    = w_legal ? w_op    : 6'd0;
   assign w_funct_fwd = w_legal ? w_funct : 6'd0;
   assign w_rt_fwd    = w_legal ? w_rt    : '0;

   // ---------------------------------------------------------- ID/EX state
   logic r_mem_read_ex;
   logic r_mem_write_ex;
   logic [1:0] r_mem_size_ex;
   logic r_reg_write_ex;
   logic r_mem_to_reg_ex;
   logic r_link_ex;
   // EX/MEM state not visible on ports
   logic r_reg_write_mem;
   logic r_mem_to_reg_mem;
   logic r_link_mem;

   // -------------------------------------------------------------- hazards
   logic w_load_use;
   logic w_stall;
   logic w_flush;

   assign w_load_use = r_mem_read_ex && (DestEX != '0) && InstrValid &&
                       ((DestEX == w_rs) || ((DestEX == w_rt) && w_uses_rt));

   // A taken branch discards the ID instruction anyway, so it masks the stall.
   assign w_stall = (EN_HAZARD != 0) && !Rst && !BranchTakenEX && w_load_use;

   // A jump only flushes on the cycle it actually leaves ID; while stalled
   // the jump is still sitting in IF/ID and must not be zeroed.
   assign w_flush = !Rst && (BranchTakenEX || (w_jump && !w_stall));

   assign Stall     = w_stall;
   assign FlushIFID = w_flush;

   // --------------------------------------------------------------- stages
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ALUSrcEX         <= 1'b0;
         RegDstEX         <= 1'b0;
         BranchEX         <= 1'b0;
         OPCodeEX         <= 6'd0;
         FunctEX          <= 6'd0;
         RtFieldEX        <= '0;
         DestEX           <= '0;
         r_mem_read_ex    <= 1'b0;
         r_mem_write_ex   <= 1'b0;
         r_mem_size_ex    <= 2'b00;
         r_reg_write_ex   <= 1'b0;
         r_mem_to_reg_ex  <= 1'b0;
         r_link_ex        <= 1'b0;
         MemReadMEM       <= 1'b0;
         MemWriteMEM      <= 1'b0;
         MemSizeMEM       <= 2'b00;
         DestMEM          <= '0;
         r_reg_write_mem  <= 1'b0;
         r_mem_to_reg_mem <= 1'b0;
         r_link_mem       <= 1'b0;
         RegWriteWB       <= 1'b0;
         MemtoRegWB       <= 1'b0;
         LinkWB           <= 1'b0;
         DestWB           <= '0;
      end else begin
         if (BranchTakenEX || w_stall) begin
            ALUSrcEX        <= 1'b0;
            RegDstEX        <= 1'b0;
            BranchEX        <= 1'b0;
            OPCodeEX        <= 6'd0;
            FunctEX         <= 6'd0;
            RtFieldEX       <= '0;
            DestEX          <= '0;
            r_mem_read_ex   <= 1'b0;
            r_mem_write_ex  <= 1'b0;
            r_mem_size_ex   <= 2'b00;
            r_reg_write_ex  <= 1'b0;
            r_mem_to_reg_ex <= 1'b0;
            r_link_ex       <= 1'b0;
         end else begin
            ALUSrcEX        <= w_alu_src;
            RegDstEX        <= w_reg_dst;
            BranchEX        <= w_branch;
            OPCodeEX        <= w_op_fwd;
            FunctEX         <= w_funct_fwd;
            RtFieldEX       <= w_rt_fwd;
            DestEX          <= w_dest;
            r_mem_read_ex   <= w_mem_read;
            r_mem_write_ex  <= w_mem_write;
            r_mem_size_ex   <= w_mem_size;
            r_reg_write_ex  <= w_reg_write;
            r_mem_to_reg_ex <= w_mem_to_reg;
            r_link_ex       <= w_link;
         end

         MemReadMEM       <= r_mem_read_ex;
         MemWriteMEM      <= r_mem_write_ex;
         MemSizeMEM       <= r_mem_size_ex;
         DestMEM          <= DestEX;
         r_reg_write_mem  <= r_reg_write_ex;
         r_mem_to_reg_mem <= r_mem_to_reg_ex;
         r_link_mem       <= r_link_ex;

         RegWriteWB       <= r_reg_write_mem;
         MemtoRegWB       <= r_mem_to_reg_mem;
         LinkWB           <= r_link_mem;
         DestWB           <= DestMEM;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//   Directed bench for pipe_ctrl_unit. Each table row is one ID-stage cycle
//   with hand-computed decode and hand-computed Stall/FlushIFID. The driver
//   pushes the expected snapshot of all outputs for that cycle; a separate
//   monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

   typedef struct packed {
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_size;
      logic       reg_write;
      logic       mem_to_reg;
      logic       link;
      logic [5:0] op;
      logic [5:0] funct;
      logic [4:0] rt;
      logic [4:0] dest;
   } ctl_t;

   typedef struct packed {
      logic stall;
      logic flush;
      ctl_t ex;
      ctl_t mem;
      ctl_t wb;
   } snap_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        valid;
      logic        bt;
      logic        rst;
      logic        stall;
      logic        flush;
      ctl_t        dec;
   } vec_t;

   // ------------------------------------------------------ clock / reset
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_id = 32'd0;
   logic        instr_valid = 1'b0;
   logic        branch_taken = 1'b0;

   always #5 clk = ~clk;

   logic       stall, flush_ifid;
   logic       alu_src_ex, reg_dst_ex, branch_ex;
   logic [5:0] opcode_ex, funct_ex;
   logic [4:0] rt_field_ex;
   logic       mem_read_mem, mem_write_mem;
   logic [1:0] mem_size_mem;
   logic       reg_write_wb, mem_to_reg_wb, link_wb;
   logic [4:0] dest_ex, dest_mem, dest_wb;

   pipe_ctrl_unit dut (
      .Clk           (clk),
      .Rst           (rst),
      .InstrID       (instr_id),
      .InstrValid    (instr_valid),
      .BranchTakenEX (branch_taken),
      .Stall         (stall),
      .FlushIFID     (flush_ifid),
      .ALUSrcEX      (alu_src_ex),
      .RegDstEX      (reg_dst_ex),
      .BranchEX      (branch_ex),
      .OPCodeEX      (opcode_ex),
      .FunctEX       (funct_ex),
      .RtFieldEX     (rt_field_ex),
      .MemReadMEM    (mem_read_mem),
      .MemWriteMEM   (mem_write_mem),
      .MemSizeMEM    (mem_size_mem),
      .RegWriteWB    (reg_write_wb),
      .MemtoRegWB    (mem_to_reg_wb),
      .LinkWB        (link_wb),
      .DestEX        (dest_ex),
      .DestMEM       (dest_mem),
      .DestWB        (dest_wb)
   );

   // ------------------------------------------------------------ scoreboard
   snap_t exp_q[$];
   vec_t  vec_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // monitor: every falling edge with an expectation pending
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         snap_t s;
         s = exp_q.pop_front();
         check("stall", {31'd0, stall}, {31'd0, s.stall});
         check("flush_ifid", {31'd0, flush_ifid}, {31'd0, s.flush});
         check("ex_stage",
               {7'd0, alu_src_ex, reg_dst_ex, branch_ex, opcode_ex, funct_ex, rt_field_ex, dest_ex},
               {7'd0, s.ex.alu_src, s.ex.reg_dst, s.ex.branch, s.ex.op, s.ex.funct, s.ex.rt, s.ex.dest});
         check("mem_stage",
               {23'd0, mem_read_mem, mem_write_mem, mem_size_mem, dest_mem},
               {23'd0, s.mem.mem_read, s.mem.mem_write, s.mem.mem_size, s.mem.dest});
         check("wb_stage",
               {24'd0, reg_write_wb, mem_to_reg_wb, link_wb, dest_wb},
               {24'd0, s.wb.reg_write, s.wb.mem_to_reg, s.wb.link, s.wb.dest});
      end
   end

   // ------------------------------------------------------------ stimulus
   function automatic ctl_t mk(input logic a, input logic rd, input logic br,
                               input logic mr, input logic mw, input logic [1:0] sz,
                               input logic rw, input logic m2r, input logic lk,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rt, input logic [4:0] ds);
      ctl_t c;
      c = '{alu_src:a, reg_dst:rd, branch:br, mem_read:mr, mem_write:mw, mem_size:sz,
            reg_write:rw, mem_to_reg:m2r, link:lk, op:op, funct:fn, rt:rt, dest:ds};
      return c;
   endfunction

   task automatic add(input logic [31:0] ins, input logic v, input logic bt, input logic r,
                      input logic st, input logic fl, input ctl_t d);
      vec_t x;
      x = '{instr:ins, valid:v, bt:bt, rst:r, stall:st, flush:fl, dec:d};
      vec_q.push_back(x);
   endtask

   ctl_t z, d_lw8, d_add10, d_addi8, d_lw0, d_add10z, d_jal, d_jr, d_beq;
   ctl_t d_sw8, d_lb5, d_sh5, d_add0, d_bgez;
   ctl_t m_ex, m_mem, m_wb;

   initial begin
      //           a  rd br mr mw sz     rw m2 lk op     funct  rt     dest
      z        = '0;
      d_lw8    = mk(1, 0, 0, 1, 0, 2'd2, 1, 1, 0, 6'h23, 6'h00, 5'd8,  5'd8);
      d_add10  = mk(0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 6'h00, 6'h20, 5'd11, 5'd10);
      d_addi8  = mk(1, 0, 0, 0, 0, 2'd0, 1, 0, 0, 6'h08, 6'h05, 5'd8,  5'd8);
      d_lw0    = mk(1, 0, 0, 1, 0, 2'd2, 0, 1, 0, 6'h23, 6'h00, 5'd0,  5'd0);
      d_add10z = mk(0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 6'h00, 6'h20, 5'd0,  5'd10);
      d_jal    = mk(0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 6'h03, 6'h10, 5'd0,  5'd31);
      d_jr     = mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 6'h00, 6'h08, 5'd0,  5'd0);
      d_beq    = mk(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 6'h04, 6'h04, 5'd8,  5'd0);
      d_sw8    = mk(1, 0, 0, 0, 1, 2'd2, 0, 0, 0, 6'h2B, 6'h00, 5'd8,  5'd0);
      d_lb5    = mk(1, 0, 0, 1, 0, 2'd0, 1, 1, 0, 6'h20, 6'h00, 5'd5,  5'd5);
      d_sh5    = mk(1, 0, 0, 0, 1, 2'd1, 0, 0, 0, 6'h29, 6'h02, 5'd5,  5'd0);
      d_add0   = mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 6'h00, 6'h20, 5'd11, 5'd0);
      d_bgez   = mk(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 6'h01, 6'h04, 5'd1,  5'd0);

      //   instr         v  bt rst st fl dec
      add(32'h0C000010, 1, 0, 1, 0, 0, z);        // reset: JAL must not flush
      add(32'h0C000010, 1, 0, 1, 0, 0, z);
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);    // LW $8,0($9)
      add(32'h010B5020, 1, 0, 0, 1, 0, d_add10);  // ADD $10,$8,$11 -> stall
      add(32'h010B5020, 1, 0, 0, 0, 0, d_add10);
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'h20080005, 1, 0, 0, 0, 0, d_addi8);  // ADDI $8,$0,5: no stall
      add(32'h8D200000, 1, 0, 0, 0, 0, d_lw0);    // LW $0
      add(32'h00005020, 1, 0, 0, 0, 0, d_add10z); // ADD $10,$0,$0: no stall
      add(32'h0C000010, 1, 0, 0, 0, 1, d_jal);    // JAL
      add(32'h03E00008, 1, 0, 0, 0, 1, d_jr);     // JR $31
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'h10280004, 1, 0, 0, 1, 0, d_beq);    // BEQ $1,$8: rt use stalls
      add(32'h10280004, 1, 0, 0, 0, 0, d_beq);
      add(32'h010B5020, 1, 1, 0, 0, 1, d_add10);  // BEQ taken in EX
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'h010B5020, 1, 1, 0, 0, 1, d_add10);  // taken branch masks stall
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'hAD280000, 1, 0, 0, 1, 0, d_sw8);    // SW $8: store rt stalls
      add(32'hAD280000, 1, 0, 0, 0, 0, d_sw8);
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'h010B5020, 0, 0, 0, 0, 0, z);        // invalid consumer: no stall
      add(32'h81250000, 1, 0, 0, 0, 0, d_lb5);    // LB $5
      add(32'hA5250002, 1, 0, 0, 1, 0, d_sh5);    // SH $5 -> stall
      add(32'hA5250002, 1, 0, 0, 0, 0, d_sh5);
      add(32'h04050000, 1, 0, 0, 0, 0, z);        // REGIMM rt=5: NOP
      add(32'hFC000000, 1, 0, 0, 0, 0, z);        // opcode 3F: NOP
      add(32'h010B0020, 1, 0, 0, 0, 0, d_add0);   // ADD $0: no write
      add(32'h04610004, 1, 0, 0, 0, 0, d_bgez);   // BGEZ $3
      add(32'h0C000010, 0, 0, 0, 0, 0, z);        // invalid JAL: no flush
      add(32'h8D280000, 1, 0, 0, 0, 0, d_lw8);
      add(32'h010B5020, 1, 0, 1, 0, 0, z);        // reset during load-use
      add(32'h010B5020, 1, 0, 0, 0, 0, d_add10);  // decodes normally after
      add(32'h00000000, 0, 0, 0, 0, 0, z);
      add(32'h00000000, 0, 0, 0, 0, 0, z);
      add(32'h00000000, 0, 0, 0, 0, 0, z);

      m_ex = '0; m_mem = '0; m_wb = '0;

      // driver: first edge happens with Rst=1, so the model starts at zero
      while (vec_q.size() > 0) begin
         vec_t v;
         snap_t s;
         v = vec_q.pop_front();
         @(posedge clk);
         #1;
         instr_id     = v.instr;
         instr_valid  = v.valid;
         branch_taken = v.bt;
         rst          = v.rst;
         s = '{stall:v.stall, flush:v.flush, ex:m_ex, mem:m_mem, wb:m_wb};
         exp_q.push_back(s);
         if (v.rst) begin
            m_wb = '0; m_mem = '0; m_ex = '0;
         end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (v.stall || v.bt) ? z : v.dec;
         end
      end

      begin
         int budget;
         budget = 20;
         while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
